// File: rtl/fetch_prefetch_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Default sizing and queue-entry layout shared by the prefetch
//               queue top level and its FIFO.
// Revision    : 1.0  initial release
// ============================================================================
package fetch_pkg;

   localparam int           DEF_XLEN     = 32;
   localparam int           DEF_ILEN     = 32;
   localparam int           DEF_DEPTH    = 4;
   localparam logic [31:0]  DEF_RESET_PC = 32'h0000_0000;

   // Entry layout, MSB to LSB: {instr, pc, pc_plus4}
   localparam int           DEF_INSTR_W  = DEF_ILEN;
   localparam int           DEF_PC_W     = DEF_XLEN;
   localparam int           DEF_PC4_W    = DEF_XLEN;

   // Total entry width for a given PC / instruction width.
   function automatic int entry_width(input int xlen, input int ilen);
      return ilen + 2 * xlen;
   endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_prefetch_queue_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fetch_fifo
// Description : Show-ahead FIFO with synchronous flush. Storage is not reset;
//               only the pointers and the entry count are.
// Revision    : 1.0  initial release
// ============================================================================
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int WIDTH = entry_width(DEF_XLEN, DEF_ILEN),
   parameter int DEPTH = DEF_DEPTH
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push_i,
   input  logic                       pop_i,
   input  logic                       flush_i,
   input  logic [WIDTH-1:0]           data_i,
   output logic [WIDTH-1:0]           head_o,
   output logic [$clog2(DEPTH+1)-1:0] count_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wptr_q, wptr_d;
   logic [AW-1:0]    rptr_q, rptr_d;
   logic [CW-1:0]    count_q, count_d;

   // Next pointers and count; flush beats any simultaneous push or pop.
   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (flush_i) begin
         wptr_d  = '0;
         rptr_d  = '0;
         count_d = '0;
      end else begin
         if (push_i) wptr_d = wptr_q + AW'(1);
         if (pop_i)  rptr_d = rptr_q + AW'(1);
         case ({push_i, pop_i})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // Pointer and count registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   // Entry storage; a write during flush is harmless since the pointers reset.
   always_ff @(posedge clk) begin
      if (push_i) mem_q[wptr_q] <= data_i;
   end

   assign head_o  = mem_q[rptr_q];
   assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/fetch_prefetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : fetch_prefetch_queue
// Description : Instruction fetch unit: PC register, credit-based request
//               throttling, redirect/kill handling and a show-ahead queue of
//               {instr, pc, pc+4} entries feeding decode.
// Revision    : 1.0  initial release
// ============================================================================
module fetch_prefetch_queue
   import fetch_pkg::*;
#(
   parameter int              XLEN     = DEF_XLEN,
   parameter int              ILEN     = DEF_ILEN,
   parameter int              DEPTH    = DEF_DEPTH,
   parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEF_RESET_PC)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       redirect_e,
   input  logic [XLEN-1:0]            redirect_pc_e,
   output logic                       imem_req,
   output logic [XLEN-1:0]            imem_addr,
   input  logic [ILEN-1:0]            imem_rdata,
   output logic                       valid_d,
   input  logic                       ready_d,
   output logic [ILEN-1:0]            instr_d,
   output logic [XLEN-1:0]            pc_d,
   output logic [XLEN-1:0]            pc_plus4_d,
   output logic [$clog2(DEPTH+1)-1:0] occupancy
);

   localparam int CW = $clog2(DEPTH+1);
   localparam int EW = entry_width(XLEN, ILEN);

   logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
   logic [XLEN-1:0] req_pc_q,   req_pc_d;
   logic            inflight_q, inflight_d;

   logic            fifo_push;
   logic            fifo_pop;
   logic [EW-1:0]   fifo_wdata;
   logic [EW-1:0]   fifo_head;
   logic [CW-1:0]   fifo_count;
   logic [CW:0]     credit_used;

   // Credit: never have more queued plus outstanding than the queue can hold.
   always_comb begin
      credit_used = {1'b0, fifo_count} + {{CW{1'b0}}, inflight_q};
      imem_req    = !rst && !redirect_e && (credit_used < (CW+1)'(DEPTH));
   end

   // Next fetch PC, outstanding-request flag and the PC of that request.
   always_comb begin
      fetch_pc_d = fetch_pc_q;
      if (redirect_e)    fetch_pc_d = redirect_pc_e;
      else if (imem_req) fetch_pc_d = fetch_pc_q + XLEN'(4);
      inflight_d = imem_req;
      req_pc_d   = imem_req ? fetch_pc_q : req_pc_q;
   end

   // Fetch PC and inflight flag; reset and redirect both drop any response.
   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc_q <= RESET_PC;
         inflight_q <= 1'b0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         inflight_q <= inflight_d;
      end
   end

   // PC of the outstanding request; only meaningful while inflight_q is set.
   always_ff @(posedge clk) begin
      req_pc_q <= req_pc_d;
   end

   // A response arriving in a redirect cycle is killed; that cycle's pop is
   // discarded because the flush empties the queue anyway.
   assign fifo_push  = inflight_q && !redirect_e && !rst;
   assign fifo_pop   = valid_d && ready_d && !redirect_e;
   assign fifo_wdata = {imem_rdata, req_pc_q, req_pc_q + XLEN'(4)};

   fetch_fifo #(
      .WIDTH (EW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (fifo_push),
      .pop_i   (fifo_pop),
      .flush_i (redirect_e),
      .data_i  (fifo_wdata),
      .head_o  (fifo_head),
      .count_o (fifo_count)
   );

   assign imem_addr  = fetch_pc_q;
   assign occupancy  = rst ? '0 : fifo_count;
   assign valid_d    = !rst && (fifo_count != '0);
   assign instr_d    = valid_d ? fifo_head[EW-1 -: ILEN]     : '0;
   assign pc_d       = valid_d ? fifo_head[2*XLEN-1 -: XLEN] : '0;
   assign pc_plus4_d = valid_d ? fifo_head[XLEN-1:0]         : '0;

endmodule
`default_nettype wire

// File: tb/tb_fetch_prefetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_prefetch_queue
// Description : Directed self-checking bench for fetch_prefetch_queue. The
//               memory model returns addr ^ 32'hA5A5A5A5 one cycle after each
//               request and a marker value otherwise.
// Revision    : 1.0  initial release
// ============================================================================
module tb_fetch_prefetch_queue;

   localparam logic [31:0] K    = 32'hA5A5_A5A5;
   localparam logic [31:0] IDLE = 32'hDEAD_BEEF;

   logic        clk;
   logic        rst;
   logic        redirect_e;
   logic [31:0] redirect_pc_e;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        valid_d;
   logic        ready_d;
   logic [31:0] instr_d;
   logic [31:0] pc_d;
   logic [31:0] pc_plus4_d;
   logic [2:0]  occupancy;

   int n_cmp = 0;
   int n_err = 0;

   fetch_prefetch_queue #(
      .XLEN     (32),
      .ILEN     (32),
      .DEPTH    (4),
      .RESET_PC (32'h0)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .redirect_e    (redirect_e),
      .redirect_pc_e (redirect_pc_e),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_rdata    (imem_rdata),
      .valid_d       (valid_d),
      .ready_d       (ready_d),
      .instr_d       (instr_d),
      .pc_d          (pc_d),
      .pc_plus4_d    (pc_plus4_d),
      .occupancy     (occupancy)
   );

   // Clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Memory model: sample the request mid-cycle, answer just after the edge.
   initial begin
      logic        req_s;
      logic [31:0] addr_s;
      imem_rdata = IDLE;
      forever begin
         @(negedge clk);
         req_s  = imem_req;
         addr_s = imem_addr;
         @(posedge clk);
         #1;
         imem_rdata = req_s ? (addr_s ^ K) : IDLE;
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Head entry check; an empty head must read all zeros.
   task automatic chk_head(input string tag, input logic v, input logic [31:0] pc);
      logic [31:0] e_pc4, e_instr, e_pc;
      e_pc    = v ? pc : 32'h0;
      e_pc4   = v ? pc + 32'd4 : 32'h0;
      e_instr = v ? (pc ^ K) : 32'h0;
      chk({tag, ".valid"}, 64'(valid_d),    64'(v));
      chk({tag, ".pc"},    64'(pc_d),       64'(e_pc));
      chk({tag, ".pc4"},   64'(pc_plus4_d), 64'(e_pc4));
      chk({tag, ".instr"}, 64'(instr_d),    64'(e_instr));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int occ_exp [10];
      occ_exp = '{0, 0, 1, 2, 3, 4, 4, 4, 4, 4};

      rst = 1'b1; redirect_e = 1'b0; redirect_pc_e = 32'h0; ready_d = 1'b1;

      // Reset cycle
      tick(); #1;
      chk("rst.req",  64'(imem_req),  64'd0);
      chk("rst.addr", 64'(imem_addr), 64'd0);
      chk("rst.occ",  64'(occupancy), 64'd0);
      chk_head("rst", 1'b0, 32'h0);

      // Release with ready held high: 2-cycle latency, one per cycle after
      tick(); rst = 1'b0; #1;
      chk("r0.req",  64'(imem_req),  64'd1);
      chk("r0.addr", 64'(imem_addr), 64'd0);
      chk_head("r0", 1'b0, 32'h0);
      tick(); #1;
      chk("r1.addr", 64'(imem_addr), 64'd4);
      chk_head("r1", 1'b0, 32'h0);
      tick(); #1;
      chk("r2.addr", 64'(imem_addr), 64'd8);
      chk_head("r2", 1'b1, 32'd0);
      tick(); #1; chk_head("r3", 1'b1, 32'd4);
      tick(); #1; chk_head("r4", 1'b1, 32'd8);
      tick(); #1; chk_head("r5", 1'b1, 32'd12);

      // Re-reset, then stall decode so the queue saturates
      tick(); rst = 1'b1; ready_d = 1'b0; #1;
      chk("rr.req", 64'(imem_req),  64'd0);
      chk("rr.occ", 64'(occupancy), 64'd0);
      chk_head("rr", 1'b0, 32'h0);
      tick(); rst = 1'b0; #1;
      for (int i = 0; i < 10; i++) begin
         if (i != 0) begin
            tick(); #1;
         end
         chk($sformatf("stall%0d.occ", i), 64'(occupancy), 64'(occ_exp[i]));
      end
      chk("stall.req",  64'(imem_req),  64'd0);
      chk("stall.addr", 64'(imem_addr), 64'd16);

      // Drain: 0, 4, 8, 12, 16 in order with no gaps
      tick(); ready_d = 1'b1; #1;
      chk("t0.req", 64'(imem_req), 64'd0);
      chk_head("t0", 1'b1, 32'd0);
      tick(); #1; chk_head("t1", 1'b1, 32'd4);
      tick(); #1; chk_head("t2", 1'b1, 32'd8);
      tick(); #1; chk_head("t3", 1'b1, 32'd12);
      tick(); #1; chk_head("t4", 1'b1, 32'd16);

      // Build occupancy 3 with one request inflight
      tick(); ready_d = 1'b0; #1;
      chk("t5.occ", 64'(occupancy), 64'd2);
      chk_head("t5", 1'b1, 32'd20);

      // Redirect with a simultaneous pop
      tick(); redirect_e = 1'b1; redirect_pc_e = 32'h100; ready_d = 1'b1; #1;
      chk("t6.occ",  64'(occupancy), 64'd3);
      chk("t6.req",  64'(imem_req),  64'd0);
      chk("t6.addr", 64'(imem_addr), 64'd36);
      chk_head("t6", 1'b1, 32'd20);
      tick(); redirect_e = 1'b0; #1;
      chk("u0.occ",  64'(occupancy), 64'd0);
      chk("u0.addr", 64'(imem_addr), 64'h100);
      chk("u0.req",  64'(imem_req),  64'd1);
      chk_head("u0", 1'b0, 32'h0);
      tick(); #1;
      chk("u1.addr", 64'(imem_addr), 64'h104);
      chk_head("u1", 1'b0, 32'h0);
      tick(); #1; chk_head("u2", 1'b1, 32'h100);
      tick(); #1; chk_head("u3", 1'b1, 32'h104);

      // Back-to-back redirects; the last one wins, into the wrap corner
      tick(); redirect_e = 1'b1; redirect_pc_e = 32'h200; #1;
      chk("va.req", 64'(imem_req), 64'd0);
      tick(); redirect_pc_e = 32'hFFFF_FFFC; #1;
      chk("vb.addr", 64'(imem_addr), 64'h200);
      chk("vb.occ",  64'(occupancy), 64'd0);
      chk_head("vb", 1'b0, 32'h0);
      tick(); redirect_e = 1'b0; #1;
      chk("w0.addr", 64'(imem_addr), 64'hFFFF_FFFC);
      chk("w0.req",  64'(imem_req),  64'd1);
      tick(); #1;
      chk("w1.addr", 64'(imem_addr), 64'd0);
      chk_head("w1", 1'b0, 32'h0);
      tick(); #1; chk_head("w2", 1'b1, 32'hFFFF_FFFC);
      tick(); #1; chk_head("w3", 1'b1, 32'h0);

      // Reset mid-operation with two entries queued
      tick(); ready_d = 1'b0; #1;
      chk_head("w4", 1'b1, 32'd4);
      tick(); #1;
      chk("w5.occ", 64'(occupancy), 64'd2);
      rst = 1'b1; #1;
      chk("w5r.req",   64'(imem_req), 64'd0);
      chk("w5r.valid", 64'(valid_d),  64'd0);
      tick(); rst = 1'b0; ready_d = 1'b1; #1;
      chk("x0.occ",  64'(occupancy), 64'd0);
      chk("x0.addr", 64'(imem_addr), 64'd0);
      chk("x0.req",  64'(imem_req),  64'd1);
      chk_head("x0", 1'b0, 32'h0);
      tick(); #1; chk_head("x1", 1'b0, 32'h0);
      tick(); #1; chk_head("x2", 1'b1, 32'd0);
      tick(); #1; chk_head("x3", 1'b1, 32'd4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
